// File: rtl/mmio_uart_tx_if.sv
// Store/load bus between the core and the memory-mapped UART transmitter.
// The core drives the strobe, address and store data; the UART returns
// combinational load data with no wait states.
interface mmio_uart_tx_if #(
    parameter int XLEN = 32
);
    logic            write_enable;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;

    modport master (
        output write_enable,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_enable,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Register window (16 bytes at BASE_ADDR, word offset = address[3:2]):
//   0x0 TXDATA  (W)   push write_data[7:0] into the TX FIFO
//   0x4 STATUS  (R/W) {overflow, fifo_empty, fifo_full, busy}; write bit3=1 clears overflow
//   0x8 DIVISOR (R/W) clocks per bit in [15:0]; a written 0 is stored as 1
//   0xC reserved
//
// Transmit FSM:
//   state   | meaning
//   S_IDLE  | line idle (tx=1), waiting for a byte in the FIFO
//   S_START | start bit (tx=0) for frame_div clocks
//   S_DATA  | 8 data bits LSB first, frame_div clocks each
//   S_STOP  | stop bit (tx=1); on its last clock pop the next byte or go idle
module mmio_uart_tx #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] BASE_ADDR       = XLEN'(32'h1000_0000),
    parameter int              FIFO_DEPTH      = 4,
    parameter logic [15:0]     DEFAULT_DIVISOR = 16'd16
) (
    input  logic          clk,
    input  logic          n_rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Bus decode
    logic       sel;
    logic [1:0] offset;
    logic       push_req;
    logic       status_wr;
    logic       div_wr;

    assign sel       = (bus.address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign offset    = bus.address[3:2];
    assign push_req  = bus.write_enable && sel && (offset == 2'd0);
    assign status_wr = bus.write_enable && sel && (offset == 2'd1);
    assign div_wr    = bus.write_enable && sel && (offset == 2'd2);

    // Address bits [1:0] and the upper store-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.address[1:0], bus.write_data[XLEN-1:16]};

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  fifo_head;

    // Control/status registers
    logic        overflow_q, overflow_d;
    logic [15:0] divisor_q,  divisor_d;

    // Transmit FSM registers
    state_t      state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [15:0] frame_div_q;
    logic        tx_q;

    logic        pop;
    logic        push_ok;
    logic        overflow_set;
    logic        busy;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q != S_IDLE);

    // The FSM takes a byte when idle, or on the last clock of a stop bit so
    // consecutive frames run back to back.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && (timer_q == 16'd0)));

    // A pop on the same edge frees the slot, so a push to a full FIFO is kept.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    // Next-state logic for FIFO pointers and control/status registers
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        divisor_d  = divisor_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (status_wr && bus.write_data[3]) begin
            overflow_d = 1'b0;
        end
        if (overflow_set) begin
            overflow_d = 1'b1;
        end

        if (div_wr) begin
            divisor_d = (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
        end
    end

    // Register FIFO pointers, sticky overflow and the divisor
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= DEFAULT_DIVISOR;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            divisor_q  <= divisor_d;
        end
    end

    // Write accepted bytes into FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.write_data[7:0];
        end
    end

    // Transmit FSM with registered tx; divisor is latched per frame at pop time
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            timer_q     <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_div_q <= DEFAULT_DIVISOR;
            tx_q        <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q     <= fifo_head;
                        frame_div_q <= divisor_q;
                        timer_q     <= divisor_q - 16'd1;
                        bit_idx_q   <= 3'd0;
                        tx_q        <= 1'b0;
                        state_q     <= S_START;
                    end
                end

                S_START: begin
                    if (timer_q != 16'd0) begin
                        timer_q <= timer_q - 16'd1;
                    end else begin
                        timer_q   <= frame_div_q - 16'd1;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (timer_q != 16'd0) begin
                        timer_q <= timer_q - 16'd1;
                    end else begin
                        timer_q <= frame_div_q - 16'd1;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    if (timer_q != 16'd0) begin
                        timer_q <= timer_q - 16'd1;
                    end else if (pop) begin
                        shift_q     <= fifo_head;
                        frame_div_q <= divisor_q;
                        timer_q     <= divisor_q - 16'd1;
                        bit_idx_q   <= 3'd0;
                        tx_q        <= 1'b0;
                        state_q     <= S_START;
                    end else begin
                        tx_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx = tx_q;

    // Combinational load data; zero outside the window and for write-only/reserved words
    always_comb begin
        bus.read_data = '0;
        if (sel) begin
            case (offset)
                2'd1:    bus.read_data[3:0]  = {overflow_q, fifo_empty, fifo_full, busy};
                2'd2:    bus.read_data[15:0] = divisor_q;
                default: bus.read_data       = '0;
            endcase
        end
    end

endmodule
